// File: rtl/oclib_pkg.sv
// -----------------------------------------------------------------------------
// oclib_pkg
// Shared types and constants for the byte-channel / AXI-Lite bridge blocks.
//   axil_32_s       : AXI-Lite master request (aw/w/ar channels plus bready/rready)
//   axil_32_fb_s    : AXI-Lite slave feedback (ready signals, b and r channels)
//   bc_8b_bidi_s    : 8-bit byte channel {data, valid, ready}; ready flows the
//                     opposite way to data/valid
//   BcAxil*         : command and status byte encodings of the BC<->AXIL frames
//   bcAxilRespStatus: maps an AXI response code to the status byte
// -----------------------------------------------------------------------------
package oclib_pkg;

    typedef struct packed {
        logic [31:0] awaddr;
        logic [2:0]  awprot;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wvalid;
        logic        bready;
        logic [31:0] araddr;
        logic [2:0]  arprot;
        logic        arvalid;
        logic        rready;
    } axil_32_s;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rvalid;
    } axil_32_fb_s;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ready;
    } bc_8b_bidi_s;

    localparam logic [7:0] BcAxilCmdWrite    = 8'h01;
    localparam logic [7:0] BcAxilCmdRead     = 8'h02;
    localparam logic [7:0] BcAxilStatOkay    = 8'h00;
    localparam logic [7:0] BcAxilStatTimeout = 8'hFE;
    localparam logic [7:0] BcAxilStatBadCmd  = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StAxReq,
        StResp,
        StTxStat,
        StTxData
    } bc_axil_state_e;

    // OKAY maps to 0x00; any other response code is reported as 0x80|resp.
    function automatic logic [7:0] bcAxilRespStatus(input logic [1:0] resp);
        return (resp == 2'b00) ? BcAxilStatOkay : {6'b100000, resp};
    endfunction

endpackage

// File: rtl/oclib_bc_axil_shifter.sv
// -----------------------------------------------------------------------------
// oclib_bc_axil_shifter
// 4-byte MSB-first serializer/deserializer with a byte counter.
//   clock, reset : clock and asynchronous active-low reset (counter only)
//   clear        : return the byte counter to zero
//   load         : parallel-load loadData (counter returns to zero)
//   shift/byteIn : shift the word left one byte, byteIn entering at the LSB
//   word         : assembled 32-bit word
//   byteOut      : current MSB byte (next byte to transmit)
//   last         : counter is at the fourth byte of the word
// -----------------------------------------------------------------------------
module oclib_bc_axil_shifter (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] loadData,
    input  logic        shift,
    input  logic [7:0]  byteIn,
    output logic [31:0] word,
    output logic [7:0]  byteOut,
    output logic        last
);

    logic [1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || load) begin
            count <= '0;
        end else if (shift) begin
            count <= count + 2'd1;
        end
    end

    // Word contents are only meaningful once the counter says so; no reset.
    always_ff @(posedge clock) begin
        if (load) begin
            word <= loadData;
        end else if (shift) begin
            word <= {word[23:0], byteIn};
        end
    end

    assign byteOut = word[31:24];
    assign last    = (count == 2'd3);

endmodule

// File: rtl/oclib_bc_to_axil.sv
// -----------------------------------------------------------------------------
// oclib_bc_to_axil
// Byte-channel to AXI-Lite initiator. Receives read/write request frames on a
// byte channel, issues one AXI-Lite transaction per frame and answers with a
// status byte (plus four MSB-first data bytes for a successful read).
//   clock  : sole clock
//   reset  : asynchronous, active-low
//   bcIn   : request bytes (data/valid); .ready = far end accepts bcOut bytes
//   bcOut  : response bytes (data/valid); .ready = this block accepts bcIn
//   axil   : AXI-Lite master request
//   axilFb : AXI-Lite slave feedback
// Parameter TimeoutCycles bounds each AXI phase (0 disables the timeout).
// -----------------------------------------------------------------------------
module oclib_bc_to_axil
    import oclib_pkg::*;
#(
    parameter type AxilType      = oclib_pkg::axil_32_s,
    parameter type AxilFbType    = oclib_pkg::axil_32_fb_s,
    parameter type BcType        = oclib_pkg::bc_8b_bidi_s,
    parameter int  TimeoutCycles = 1024
) (
    input  logic      clock,
    input  logic      reset,
    input  BcType     bcIn,
    output BcType     bcOut,
    output AxilType   axil,
    input  AxilFbType axilFb
);

    localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TW-1:0] TLimit = TW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam bit TimeoutEn = (TimeoutCycles > 0);

    bc_axil_state_e state, nextState;

    logic          rxReady;
    logic          respReady;
    logic          isWrite;
    logic          awValid, wValid, arValid;
    logic [TW-1:0] tCount;
    logic [7:0]    status;
    logic [31:0]   addr;

    logic          rxAccept, txValid, txAccept;
    logic          reqDone, respHit, timedOut, cmdOk;
    logic [1:0]    respCode;

    logic          shClear, shLoad, shShift, shLast;
    logic [31:0]   shWord;
    logic [7:0]    shByteOut;

    oclib_bc_axil_shifter uShifter (
        .clock    (clock),
        .reset    (reset),
        .clear    (shClear),
        .load     (shLoad),
        .loadData (axilFb.rdata),
        .shift    (shShift),
        .byteIn   (bcIn.data),
        .word     (shWord),
        .byteOut  (shByteOut),
        .last     (shLast)
    );

    assign rxAccept = bcIn.valid && rxReady;
    assign txValid  = (state == StTxStat) || (state == StTxData);
    assign txAccept = txValid && bcIn.ready;
    assign cmdOk    = (bcIn.data == BcAxilCmdWrite) || (bcIn.data == BcAxilCmdRead);
    // A channel counts as finished if it was already taken or is taken now.
    assign reqDone  = (!awValid || axilFb.awready) && (!wValid || axilFb.wready) &&
                      (!arValid || axilFb.arready);
    assign respHit  = respReady && (isWrite ? axilFb.bvalid : axilFb.rvalid);
    assign respCode = isWrite ? axilFb.bresp : axilFb.rresp;
    assign timedOut = TimeoutEn && (tCount == TLimit);

    // ---- state register ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= StIdle;
        end else begin
            state <= nextState;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        nextState = state;
        unique case (state)
            StIdle:   if (rxAccept) nextState = cmdOk ? StAddr : StTxStat;
            StAddr:   if (rxAccept && shLast) nextState = isWrite ? StData : StAxReq;
            StData:   if (rxAccept && shLast) nextState = StAxReq;
            StAxReq:  if (reqDone) nextState = StResp;
                      else if (timedOut) nextState = StTxStat;
            StResp:   if (respHit || timedOut) nextState = StTxStat;
            StTxStat: if (txAccept)
                          nextState = ((status == BcAxilStatOkay) && !isWrite) ? StTxData : StIdle;
            StTxData: if (txAccept && shLast) nextState = StIdle;
            default:  nextState = StIdle;
        endcase
    end

    // ---- registered control ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxReady   <= 1'b0;
            respReady <= 1'b0;
            isWrite   <= 1'b0;
            awValid   <= 1'b0;
            wValid    <= 1'b0;
            arValid   <= 1'b0;
            tCount    <= '0;
            status    <= '0;
        end else begin
            // Registered from nextState so they track the state exactly and
            // stay low while reset is held.
            rxReady   <= (nextState == StIdle) || (nextState == StAddr) || (nextState == StData);
            respReady <= (nextState == StIdle) || (nextState == StResp);

            if (state == StIdle && rxAccept) begin
                isWrite <= (bcIn.data == BcAxilCmdWrite);
            end

            if (state != StAxReq && nextState == StAxReq) begin
                awValid <= isWrite;
                wValid  <= isWrite;
                arValid <= !isWrite;
            end else if (state == StAxReq) begin
                if (nextState == StTxStat) begin
                    awValid <= 1'b0;
                    wValid  <= 1'b0;
                    arValid <= 1'b0;
                end else begin
                    if (axilFb.awready) awValid <= 1'b0;
                    if (axilFb.wready)  wValid  <= 1'b0;
                    if (axilFb.arready) arValid <= 1'b0;
                end
            end

            if (nextState != state) begin
                tCount <= '0;
            end else if (state == StAxReq || state == StResp) begin
                tCount <= tCount + 1'b1;
            end

            if (state == StIdle && rxAccept && !cmdOk) begin
                status <= BcAxilStatBadCmd;
            end else if (state == StResp && respHit) begin
                status <= bcAxilRespStatus(respCode);
            end else if ((state == StAxReq || state == StResp) && nextState == StTxStat) begin
                status <= BcAxilStatTimeout;
            end
        end
    end

    // Address is held for the whole transaction; the shifter is reused for data.
    always_ff @(posedge clock) begin
        if (state == StAddr && rxAccept && shLast) begin
            addr <= {shWord[23:0], bcIn.data};
        end
    end

    // ---- outputs ----
    always_comb begin
        shClear = (state == StIdle);
        shShift = (((state == StAddr) || (state == StData)) && rxAccept) ||
                  ((state == StTxData) && txAccept);
        shLoad  = (state == StResp) && respHit && !isWrite && (respCode == 2'b00);

        axil         = '0;
        axil.awaddr  = addr;
        axil.awprot  = 3'b000;
        axil.awvalid = awValid;
        axil.wdata   = shWord;
        axil.wstrb   = 4'hF;
        axil.wvalid  = wValid;
        axil.bready  = respReady;
        axil.araddr  = addr;
        axil.arprot  = 3'b000;
        axil.arvalid = arValid;
        axil.rready  = respReady;

        bcOut        = '0;
        bcOut.valid  = txValid;
        bcOut.ready  = rxReady;
        if (state == StTxStat) begin
            bcOut.data = status;
        end else if (state == StTxData) begin
            bcOut.data = shByteOut;
        end
    end

endmodule

// File: doc/oclib_bc_to_axil.md
# oclib_bc_to_axil

Byte-channel-to-AXI-Lite initiator. It takes CSR read and write request frames arriving on an 8-bit bidirectional byte channel and issues single AXI-Lite master transactions. It then returns a status frame, plus read data, on the same channel. It sits at the far end of an AXIL-to-BC link, so a serial or byte-channel controller can drive any AXIL register space.

## Interface
- AxilType, oclib_pkg::axil_32_s, AXIL master request struct (aw/w/ar/bready/rready).
- AxilFbType, oclib_pkg::axil_32_fb_s, AXIL feedback struct (awready/wready/arready/b/r).
- BcType, oclib_pkg::bc_8b_bidi_s, byte channel struct {data[7:0], valid, ready}.
- TimeoutCycles, 1024, cycles allowed per AXIL phase before the transaction is abandoned; 0 disables the timeout.
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low (asserted at 0).
- bcIn  in  BcType  request bytes (data/valid); .ready = far end accepting bcOut bytes.
- bcOut  out  BcType  response bytes (data/valid); .ready = this block accepting bcIn bytes.
- axil  out  AxilType  AXIL master request.
- axilFb  in  AxilFbType  AXIL slave feedback.

## Operation
- Request frame, MSB first:
  - cmd byte: 0x01 = write, 0x02 = read.
  - 4 address bytes.
  - Write only: 4 data bytes.
- Response frame:
  - Status byte: 0x00 = OKAY; 0x80|resp[1:0] = SLVERR/DECERR; 0xFE = timeout; 0xFF = bad command.
  - Successful read only: 4 data bytes, MSB first.
- States:
  - IDLE: wait for a cmd byte.
  - ADDR: collect 4 address bytes.
  - DATA: collect 4 write data bytes.
  - AXREQ: AW+W for a write, or AR for a read.
  - RESP: wait for B or R.
  - TXSTAT: send the status byte.
  - TXDATA: send 4 read data bytes.
- Transitions:
  - Unknown cmd → TXSTAT with 0xFF, then IDLE.
  - Error response → no TXDATA.
- Write handshakes:
  - awvalid and wvalid assert in the same cycle.
  - Each deasserts independently on its own handshake.
  - RESP is entered only when both have completed.
- AXIL fixed fields: wstrb = 4'hF; awprot = arprot = 3'b000.
- bready/rready are high in RESP and in IDLE. Responses arriving after a timeout are accepted and discarded, never forwarded.
- Timeout counter:
  - Clears on entry to AXREQ and on entry to RESP.
  - Counts while the phase is pending.
  - At TimeoutCycles it drops all AXIL valids and goes to TXSTAT with 0xFE.
- bcOut.ready (RX accept) is high in IDLE/ADDR/DATA and low otherwise. The channel is never overrun when the protocol is followed.

## Timing
- Reset (reset==0) values:
  - All axil valids 0; bready = rready = 0.
  - bcOut.valid = 0; bcOut.ready = 0; bcOut.data = 0.
  - State IDLE; timeout counter 0.
- First cycle after reset release: bcOut.ready = 1.
- One byte is accepted per cycle in which bcIn.valid && bcOut.ready.
- AXIL valids assert the cycle after the last request byte is accepted.
- TXSTAT valid asserts the cycle after the B/R handshake.
- bcOut.data is stable while valid && !bcIn.ready.
- Minimum write round trip: 9 byte cycles + 1 + AXIL latency + 1 + 1 status cycle.
- Reset mid-frame or mid-transaction: immediate return to IDLE. A partial frame is discarded and no response byte is emitted.
- AXIL awready and wready arriving in different cycles are both legal and must each be held until taken.

## Structure
- Add command/status byte constants to oclib_pkg: BcAxilCmdWrite, BcAxilCmdRead, BcAxilStatTimeout, BcAxilStatBadCmd.
- One natural sub-module: oclib_bc_axil_shifter, a 4-byte MSB-first serializer/deserializer with a byte counter. It is used for the address and data RX and for the read-data TX.

## Test plan
- Write: bytes 01 00 00 10 04 DE AD BE EF → awaddr = 0x00001004, wdata = 0xDEADBEEF, wstrb = F; bresp OKAY → response 00.
- Read: bytes 02 00 00 00 08, slave returns rdata = 0x12345678 → response 00 12 34 56 78.
- Read with rresp = SLVERR (2'b10) → response 82 only; DECERR on a write → 83.
- Bad cmd 0x07 → response FF; next valid read completes normally.
- Slave never asserts arready, TimeoutCycles = 16 → arvalid drops after 16 cycles, response FE. A late rvalid is accepted and nothing is emitted.
- Reset pulsed after 3 address bytes → no output; bcOut.ready = 0 during reset. A full write issued after release completes normally.
- Backpressure: awready delayed 5 cycles relative to wready, and bcIn.ready toggled each cycle during TXDATA → single AW/W handshakes, and all bytes are delivered in order without loss.
